// File: rtl/data_mem_unit.sv
// data_mem_unit: memory-side responder for decoded load/store requests.
// Executes word/half/byte loads and stores on an internal word-wide
// synchronous RAM (big-endian byte lanes). Sub-word stores use read-modify-write.
// Loads can return the raw word or a sign/zero-extended byte or half.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    request handshake (ready only when idle)
//   re_in, we_in       load / store request
//   size_in            00 byte, 01 half, 11 word, 10 illegal
//   load_sel           11 sign byte, 10 sign half, 01 zero byte, 00 zero half
//   mem_sel            1 = raw aligned word, 0 = extended sub-word
//   addr, wdata        byte address, store data (sub-word payload in low bits)
//   resp_valid         one-cycle completion pulse
//   rdata              load result, held until the next response
//   err                with resp_valid: illegal or misaligned request
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        re_in,
  input  logic        we_in,
  input  logic [1:0]  size_in,
  input  logic [1:0]  load_sel,
  input  logic        mem_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_RSP, ST_WR, RMW_RD, RMW_WR, ERR
  } state_t;

  state_t state, state_next;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_q;

  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic [1:0]    load_sel_q;
  logic          mem_sel_q;
  logic [31:0]   wdata_q;

  logic          accept;
  logic          req_err;
  logic          wr_en;
  logic [31:0]   wr_word;
  logic [31:0]   ld_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // Address bits above the RAM index are ignored (addresses wrap).
  logic          unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && (re_in || we_in) && !rst;

  assign req_err = (re_in && we_in)
                || (size_in == 2'b10)
                || (size_in == 2'b01 && addr[0])
                || (size_in == 2'b11 && addr[1:0] != 2'b00);

  // Response outputs are decoded from state; reset suppresses them in the same cycle.
  assign resp_valid = !rst && (state inside {LD_RSP, ST_WR, RMW_WR, ERR});
  assign err        = !rst && (state == ERR);
  assign wr_en      = !rst && (state == ST_WR || state == RMW_WR);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)               state_next = ERR;
          else if (re_in)            state_next = LD_RD;
          else if (size_in == 2'b11) state_next = ST_WR;
          else                       state_next = RMW_RD;
        end
      end
      LD_RD:   state_next = LD_RSP;
      RMW_RD:  state_next = RMW_WR;
      LD_RSP,
      ST_WR,
      RMW_WR,
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdata <= '0;
    end else begin
      state <= state_next;
      if (accept && req_err)
        rdata <= '0;
      else if (state == LD_RD)
        rdata <= ld_word;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q      <= addr[AW+1:2];
      off_q      <= addr[1:0];
      size_q     <= size_in;
      load_sel_q <= load_sel;
      mem_sel_q  <= mem_sel;
      wdata_q    <= wdata;
    end
  end

  // Single RAM: the read is issued on the accept edge, so ram_q holds the old
  // word through LD_RD / RMW_RD / RMW_WR. Writes happen only in ST_WR/RMW_WR,
  // which never coincide with an accept, so read-after-write needs no bypass.
  always_ff @(posedge clk) begin
    if (accept && !req_err)
      ram_q <= mem[addr[AW+1:2]];
    if (wr_en)
      mem[idx_q] <= wr_word;
  end

  always_comb begin
    ld_byte = ram_q[7:0];
    unique case (off_q)
      2'd0:    ld_byte = ram_q[31:24];
      2'd1:    ld_byte = ram_q[23:16];
      2'd2:    ld_byte = ram_q[15:8];
      default: ld_byte = ram_q[7:0];
    endcase
    ld_half = off_q[1] ? ram_q[15:0] : ram_q[31:16];

    ld_word = ram_q;
    if (!mem_sel_q) begin
      unique case (load_sel_q)
        2'b11:   ld_word = {{24{ld_byte[7]}}, ld_byte};
        2'b01:   ld_word = {24'd0, ld_byte};
        2'b10:   ld_word = {{16{ld_half[15]}}, ld_half};
        default: ld_word = {16'd0, ld_half};
      endcase
    end
  end

  always_comb begin
    wr_word = ram_q;
    unique case (size_q)
      2'b11: wr_word = wdata_q;
      2'b01: begin
        if (off_q[1]) wr_word[15:0]  = wdata_q[15:0];
        else          wr_word[31:16] = wdata_q[15:0];
      end
      default: begin
        unique case (off_q)
          2'd0:    wr_word[31:24] = wdata_q[7:0];
          2'd1:    wr_word[23:16] = wdata_q[7:0];
          2'd2:    wr_word[15:8]  = wdata_q[7:0];
          default: wr_word[7:0]   = wdata_q[7:0];
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed steps plus random requests, checked
// against a byte-array reference model.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        re_in;
  logic        we_in;
  logic [1:0]  size_in;
  logic [1:0]  load_sel;
  logic        mem_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mb [4096];
  logic [31:0] rd_m;

  typedef struct {
    logic        r;
    logic        w;
    logic [1:0]  sz;
    logic [1:0]  ls;
    logic        ms;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  req_t bq [4];

  data_mem_unit #(.DEPTH_WORDS(1024), .AW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .re_in      (re_in),
    .we_in      (we_in),
    .size_in    (size_in),
    .load_sel   (load_sel),
    .mem_sel    (mem_sel),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-addressed, big-endian view of the RAM; updates rd_m for responses.
  function automatic void model(input logic r, input logic w, input logic [1:0] sz,
                                input logic [1:0] ls, input logic ms,
                                input logic [31:0] a, input logic [31:0] wd,
                                output int lat, output logic e);
    int b  = int'(a % 4096);
    int wb = b - (b % 4);
    int hb = b - (b % 2);
    int v;
    e = (r && w) || (sz == 2) || (sz == 1 && (a % 2) == 1) || (sz == 3 && (a % 4) != 0);
    if (e) begin
      lat  = 1;
      rd_m = '0;
    end else if (r) begin
      lat = 2;
      if (ms) begin
        rd_m = {mb[wb], mb[wb+1], mb[wb+2], mb[wb+3]};
      end else if (ls == 3 || ls == 1) begin
        v = int'(mb[b]);
        if (ls == 3 && v >= 128) v = v - 256;
        rd_m = v;
      end else begin
        v = int'(mb[hb]) * 256 + int'(mb[hb+1]);
        if (ls == 2 && v >= 32768) v = v - 65536;
        rd_m = v;
      end
    end else begin
      if (sz == 3) begin
        lat = 1;
        for (int k = 0; k < 4; k++) mb[wb+k] = 8'(wd >> (8 * (3 - k)));
      end else if (sz == 1) begin
        lat = 2;
        mb[hb]   = 8'(wd >> 8);
        mb[hb+1] = 8'(wd);
      end else begin
        lat = 2;
        mb[b] = 8'(wd);
      end
    end
  endfunction

  task automatic drive(input req_t x);
    re_in    = x.r;
    we_in    = x.w;
    size_in  = x.sz;
    load_sel = x.ls;
    mem_sel  = x.ms;
    addr     = x.a;
    wdata    = x.wd;
  endtask

  task automatic req(input string tag, input logic r, input logic w, input logic [1:0] sz,
                     input logic [1:0] ls, input logic ms,
                     input logic [31:0] a, input logic [31:0] wd);
    int          lat;
    int          got_lat;
    int          pulses;
    logic        e;
    logic        got_e;
    logic [31:0] got_rd;
    logic [31:0] exp_rd;
    @(negedge clk);
    re_in = r; we_in = w; size_in = sz; load_sel = ls; mem_sel = ms;
    addr = a; wdata = wd; req_valid = 1'b1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    model(r, w, sz, ls, ms, a, wd, lat, e);
    exp_rd = rd_m;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    {re_in, we_in, size_in, load_sel, mem_sel} = 7'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    pulses = 0; got_lat = 0; got_e = 1'b0; got_rd = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          got_lat = c;
          got_e   = err;
          got_rd  = rdata;
        end
      end
    end
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_lat"}, 32'(got_lat), 32'(lat));
    chk({tag, "_err"}, 32'(got_e), 32'(e));
    chk({tag, "_rdata"}, got_rd, exp_rd);
  endtask

  initial begin
    int          idx;
    int          wc;
    int          cur_lat;
    bit          busy;
    logic        e;
    logic [31:0] ra;
    int          kind;

    rst = 1'b1; req_valid = 1'b0; re_in = 1'b0; we_in = 1'b0;
    size_in = 2'b00; load_sel = 2'b00; mem_sel = 1'b0; addr = '0; wdata = '0;
    foreach (mb[i]) mb[i] = 8'h00;
    rd_m = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) req("fill", 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 32'(i * 4), $urandom);

    req("sw10", 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
    req("lw10", 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 32'h10, 32'h0);
    chk("lw10_val", rdata, 32'hDEADBEEF);

    req("sw20", 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 32'h20, 32'h80FF7F01);
    req("lb20", 1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 32'h20, 32'h0);
    chk("lb20_val", rdata, 32'hFFFFFF80);
    req("lbu21", 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 32'h21, 32'h0);
    chk("lbu21_val", rdata, 32'h000000FF);
    req("lb22", 1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 32'h22, 32'h0);
    chk("lb22_val", rdata, 32'h0000007F);
    req("lh22", 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 32'h22, 32'h0);
    chk("lh22_val", rdata, 32'h00007F01);
    req("lhu20", 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 32'h20, 32'h0);
    chk("lhu20_val", rdata, 32'h000080FF);
    req("sh22", 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 32'h22, 32'h1234ABCD);
    req("lw20a", 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 32'h20, 32'h0);
    chk("lw20a_val", rdata, 32'h80FFABCD);

    req("e_lw21", 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 32'h21, 32'h0);
    chk("e_lw21_val", rdata, 32'h0);
    req("e_sh23", 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 32'h23, 32'hFFFF);
    req("e_rewe", 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 32'h20, 32'h0);
    req("e_sz10", 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 32'h20, 32'h0);
    req("lw20b", 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 32'h20, 32'h0);
    chk("lw20b_val", rdata, 32'h80FFABCD);

    // Reset asserted during the write-back cycle of a byte RMW.
    req("sw30", 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 32'h30, 32'h11223344);
    @(negedge clk);
    re_in = 1'b0; we_in = 1'b1; size_in = 2'b00; load_sel = 2'b00; mem_sel = 1'b0;
    addr = 32'h30; wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmwrst_rd_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rmwrst_wr_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd_m = '0;
    @(negedge clk);
    chk("rmwrst_ready", 32'(req_ready), 32'd1);
    chk("rmwrst_rdata", rdata, 32'd0);
    chk("rmwrst_resp", 32'(resp_valid), 32'd0);
    req("lw30", 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 32'h30, 32'h0);
    chk("lw30_val", rdata, 32'h11223344);

    req("sw1000", 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 32'h1000, 32'hCAFEF00D);
    req("lw0", 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 32'h0, 32'h0);
    chk("lw0_val", rdata, 32'hCAFEF00D);

    for (int n = 0; n < 60; n++) begin
      ra   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31));
      kind = $urandom_range(0, 5);
      req("rnd", kind != 1 && kind != 2, kind == 1 || kind == 2 || kind == 5,
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ra, $urandom);
    end

    // Back-to-back with req_valid held high.
    bq[0] = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 32'h40, 32'hA5A5A5A5};
    bq[1] = '{1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 32'h40, 32'h0};
    bq[2] = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h43, 32'h3C};
    bq[3] = '{1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 32'h43, 32'h0};
    @(negedge clk);
    drive(bq[0]);
    req_valid = 1'b1;
    idx = 0; wc = 0; cur_lat = 0; busy = 1'b0;
    for (int cyc = 0; cyc < 40 && !(idx == 4 && !busy); cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (busy) begin
        wc++;
        chk("b2b_busy_ready", 32'(req_ready), 32'd0);
        chk("b2b_resp", 32'(resp_valid), 32'(wc == cur_lat));
        if (wc == cur_lat) begin
          chk("b2b_rdata", rdata, rd_m);
          busy = 1'b0;
        end
      end else begin
        chk("b2b_idle_ready", 32'(req_ready), 32'd1);
        chk("b2b_idle_resp", 32'(resp_valid), 32'd0);
        model(bq[idx].r, bq[idx].w, bq[idx].sz, bq[idx].ls, bq[idx].ms,
              bq[idx].a, bq[idx].wd, cur_lat, e);
        @(posedge clk);
        #1;
        idx++;
        busy = 1'b1;
        wc = 0;
        if (idx < 4) drive(bq[idx]);
        else begin
          re_in = 1'b0;
          we_in = 1'b0;
        end
      end
    end
    chk("b2b_done", 32'(idx), 32'd4);
    chk("b2b_lbu_val", rdata, 32'h0000003C);

    // req_valid high with neither re_in nor we_in: never accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("noop_resp", 32'(resp_valid), 32'd0);
      chk("noop_ready", 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Memory-side responder for the load/store control signals produced by instruction decode: re_in, we_in, size_in, load_sel, mem_sel.
- Executes word, half and byte loads and stores against an internal word-wide synchronous RAM.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Sits between the ALU address result and the MemToReg write-back mux; returns one response per accepted request.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; must be a power of 2.
- AW, 10, word-index width, equal to log2(DEPTH_WORDS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- re_in  in  1  load request.
- we_in  in  1  store request.
- size_in  in  2  access size: 00 byte, 01 half, 11 word, 10 illegal.
- load_sel  in  2  load extension: 11 sign byte, 10 sign half, 01 zero byte, 00 zero half.
- mem_sel  in  1  1 = return the raw aligned word; 0 = apply load_sel extension.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data; the sub-word payload is in the low bits.
- resp_valid  out  1  one-cycle pulse: the request has completed.
- rdata  out  32  load result; held until the next response.
- err  out  1  valid with resp_valid; marks an illegal or misaligned request.

Behaviour:
- Reset values: state IDLE, req_ready 1, resp_valid 0, rdata 0, err 0. RAM contents are not reset.
- Accept rule: a request is accepted when req_valid && req_ready && (re_in || we_in). The accept cycle is T. A request with re_in=0 and we_in=0 is never accepted and produces no response.
- req_ready is 1 only in IDLE. All request fields are captured at T; later input changes are ignored.
- Byte order is big-endian: byte offset 0 is bits 31:24, offset 3 is bits 7:0.
- RAM word index is addr[AW+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Error check at T. Any of these conditions is an error:
  - re_in && we_in;
  - size_in==10;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0.
- Error response: state ERR at T+1 with resp_valid=1, err=1, rdata=0. No RAM access and no RAM write occur.
- States: IDLE, LD_RD, LD_RSP, ST_WR, RMW_RD, RMW_WR, ERR. Every state except IDLE returns to IDLE after one cycle.
- Load, latency 2:
  - IDLE -> LD_RD at T (RAM read issued).
  - LD_RD -> LD_RSP: at T+2 resp_valid=1, err=0, and rdata is updated.
  - mem_sel=1: rdata is the full word, regardless of size_in.
  - mem_sel=0: the byte or half is selected by addr[1:0] (half by addr[1]) and extended per load_sel. A size/load_sel mismatch follows load_sel.
- Word store, latency 1: IDLE -> ST_WR. The RAM is written at T+1, with resp_valid=1 and err=0. rdata is unchanged.
- Sub-word store, latency 2:
  - IDLE -> RMW_RD (old word read) -> RMW_WR.
  - In RMW_WR, at T+2, only the addressed byte (wdata[7:0]) or half (wdata[15:0]) lanes are replaced and the word is written back, with resp_valid=1.
- resp_valid is high for exactly one cycle per accepted request. At most one request is outstanding, with no overlap or pipelining.
- A new request can be accepted in the cycle after resp_valid. Minimum spacing is 2 cycles for a word store and 3 cycles for loads and sub-word stores.
- Reset mid-operation: rst=1 in any state forces IDLE at the next edge, suppresses resp_valid, and clears rdata and err.
  - The RAM write enable is gated by !rst, so a write in ST_WR or RMW_WR is cancelled if rst is high in that cycle.
  - A cancelled RMW leaves the RAM word unchanged.
- Read-after-write: a load accepted in the cycle after a store's resp_valid must see the stored data. The RAM is written before the next read is issued, so no bypass is needed.

Test Plan:
- Word store then word load:
  - Stimulus: sw addr=0x10 wdata=0xDEADBEEF, then load addr=0x10 with mem_sel=1.
  - Required: resp_valid at T+1 for the store; rdata=0xDEADBEEF at T+2 of the load; err=0.
- Byte loads with extension:
  - Setup: word 0x80FF7F01 stored at 0x20.
  - lb addr=0x20 (load_sel 11) -> 0xFFFFFF80.
  - lbu addr=0x21 (load_sel 01) -> 0x000000FF.
  - lb addr=0x22 -> 0x0000007F.
- Halfword paths:
  - lh addr=0x22 (load_sel 10) -> 0x00007F01.
  - lhu addr=0x20 (load_sel 00) -> 0x000080FF.
  - sh addr=0x22 wdata=0x1234ABCD -> word reads 0x80FFABCD; resp_valid at T+2.
- Misaligned and illegal requests:
  - lw addr=0x21, sh addr=0x23, re_in=we_in=1, and size_in=10 each give err=1 and rdata=0 at T+1.
  - Target words are unchanged when read back afterwards.
- Reset mid-RMW:
  - Stimulus: sb addr=0x30 wdata=0x55 over word 0x11223344, with rst high in the RMW_WR cycle.
  - Required: no resp_valid; the word still reads 0x11223344; req_ready=1 the cycle after reset.
- Wrap-around and back-to-back:
  - With DEPTH_WORDS=1024, sw addr=0x1000 aliases word 0.
  - req_valid held high continuously: the next request is accepted exactly the cycle after each resp_valid.
  - req_valid with re_in=we_in=0 produces no response.
